mem_access_unit: RTL and testbench

//  Data-memory side of the MemRead/MemWrite command interface driven by the instruction decoder.

---
 rtl/mem_access_unit_pkg.sv | 20 ++
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit_byte_lane_merge.sv | 50 +++++
 rtl/mem_access_unit.sv | 126 ++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types for the data-memory access unit
package mem_access_pkg;

    // Access size codes, matching the decoder's MemRead/MemWrite encoding.
    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_HALF = 2'b10,
        SZ_BYTE = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline-side MemRead/MemWrite command bus
// Purpose: groups the decoder request and the load/stall/done response.
// Signals:
//   MemRead, MemWrite  request size codes (00 none, 01 word, 10 half, 11 byte)
//   Address, WriteData byte address and store data
//   ReadData           load result, held until the next load completes
//   Stall, Done        pipeline hold and one-cycle completion pulse
//   AlignErr           one-cycle pulse with Done for an illegal request
interface mem_access_unit_if;
    logic [1:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Done;
    logic        AlignErr;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, Stall, Done, AlignErr
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, Stall, Done, AlignErr
    );
endinterface

// File: rtl/mem_access_unit_byte_lane_merge.sv
// rtl/mem_access_unit_byte_lane_merge.sv - little-endian lane extract and merge
// Purpose: combinational lane handling for sub-word loads and stores.
// Ports:
//   i_old       word read from SRAM
//   i_new       store data (byte in [7:0], half in [15:0])
//   i_size      access size code
//   i_offset    byte offset within the word
//   i_signed    1: sign-extend extracted byte/half, 0: zero-extend
//   o_merged    i_old with the addressed lane(s) replaced by i_new
//   o_extracted addressed lane(s) of i_old, extended to 32 bits
module byte_lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  size_e       i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_signed,
    output logic [31:0] o_merged,
    output logic [31:0] o_extracted
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_merged    = i_new;
        o_extracted = i_old;
        w_byte      = i_old[{i_offset, 3'b000} +: 8];
        // Half lane is chosen by offset bit 1 only; bit 0 is known zero here.
        w_half      = i_old[{i_offset[1], 4'b0000} +: 16];
        case (i_size)
            SZ_BYTE: begin
                o_merged = i_old;
                o_merged[{i_offset, 3'b000} +: 8] = i_new[7:0];
                o_extracted = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_merged = i_old;
                o_merged[{i_offset[1], 4'b0000} +: 16] = i_new[15:0];
                o_extracted = {{16{i_signed & w_half[15]}}, w_half};
            end
            default: begin
                o_merged    = i_new;
                o_extracted = i_old;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit against a single-port word SRAM
// Purpose: executes word/half/byte loads and stores; sub-word stores use
// read-modify-write. Stall holds the pipeline until Done.
// Ports:
//   Clk, Reset  clock (rising edge), asynchronous active-high reset
//   bus         pipeline command bus (slave side)
//   mem_addr    SRAM word address, captured at accept
//   mem_wdata   SRAM write data
//   mem_we      SRAM write enable, one cycle per write
//   mem_re      SRAM read enable; mem_rdata valid the following cycle
//   mem_rdata   SRAM read data
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SIGNED = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_access_unit_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);

    state_e             r_state;
    state_e             w_next;
    size_e              r_size;
    logic               r_store;
    logic [1:0]         r_offset;
    logic [15:0]        r_wdata;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_read_data;
    logic               r_err;

    logic               w_request;
    size_e              w_size;
    logic               w_illegal;
    logic               w_accept;
    logic [31:0]        w_merged;
    logic [31:0]        w_extracted;

    assign w_request = (bus.MemRead != SZ_NONE) || (bus.MemWrite != SZ_NONE);
    assign w_size    = size_e'((bus.MemRead != SZ_NONE) ? bus.MemRead : bus.MemWrite);
    assign w_illegal = ((bus.MemRead != SZ_NONE) && (bus.MemWrite != SZ_NONE))
                    || ((w_size == SZ_HALF) && bus.Address[0])
                    || ((w_size == SZ_WORD) && (bus.Address[1:0] != 2'b00));
    assign w_accept  = (r_state == ST_IDLE) && w_request;

    byte_lane_merge u_lane (
        .i_old       (mem_rdata),
        .i_new       ({16'h0000, r_wdata}),
        .i_size      (r_size),
        .i_offset    (r_offset),
        .i_signed    (SIGNED != 0),
        .o_merged    (w_merged),
        .o_extracted (w_extracted)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_request) begin
                    if (w_illegal)
                        w_next = ST_DONE;
                    else if (bus.MemWrite == SZ_WORD)
                        w_next = ST_WR;
                    else
                        w_next = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  w_next = ST_RD_WAIT;
            ST_RD_WAIT: w_next = r_store ? ST_WR : ST_DONE;
            ST_WR:      w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_size      <= SZ_NONE;
            r_store     <= 1'b0;
            r_offset    <= 2'b00;
            r_wdata     <= 16'h0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_read_data <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_size     <= w_size;
                r_store    <= (bus.MemWrite != SZ_NONE);
                r_offset   <= bus.Address[1:0];
                r_wdata    <= bus.WriteData[15:0];
                r_mem_addr <= bus.Address[ADDR_W+1:2];
                r_err      <= w_illegal;
                // Word stores skip the read phase, so their data is loaded here.
                if (!w_illegal && (bus.MemWrite == SZ_WORD))
                    r_mem_wdata <= bus.WriteData;
            end
            if (r_state == ST_RD_WAIT) begin
                if (r_store)
                    r_mem_wdata <= w_merged;
                else
                    r_read_data <= w_extracted;
            end
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_re       = (r_state == ST_RD_REQ);
    assign mem_we       = (r_state == ST_WR);
    assign bus.ReadData = r_read_data;
    assign bus.Done     = (r_state == ST_DONE);
    assign bus.AlignErr = (r_state == ST_DONE) && r_err;
    assign bus.Stall    = w_accept || ((r_state != ST_IDLE) && (r_state != ST_DONE));

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    mem_access_unit_if bus_s ();
    mem_access_unit_if bus_u ();

    logic [AW-1:0] addr_s, addr_u;
    logic [31:0]   wdata_s, wdata_u, rdata_s, rdata_u;
    logic          we_s, we_u, re_s, re_u;

    mem_access_unit #(.ADDR_W(AW), .SIGNED(1)) u_dut_s (
        .Clk(Clk), .Reset(Reset), .bus(bus_s.slave),
        .mem_addr(addr_s), .mem_wdata(wdata_s), .mem_we(we_s),
        .mem_re(re_s), .mem_rdata(rdata_s)
    );

    mem_access_unit #(.ADDR_W(AW), .SIGNED(0)) u_dut_u (
        .Clk(Clk), .Reset(Reset), .bus(bus_u.slave),
        .mem_addr(addr_u), .mem_wdata(wdata_u), .mem_we(we_u),
        .mem_re(re_u), .mem_rdata(rdata_u)
    );

    logic [31:0] sram_s [DEPTH];
    logic [31:0] sram_u [DEPTH];

    always @(posedge Clk) begin
        if (we_s) sram_s[addr_s] <= wdata_s;
        if (re_s) rdata_s <= sram_s[addr_s];
        if (we_u) sram_u[addr_u] <= wdata_u;
        if (re_u) rdata_u <= sram_u[addr_u];
    end

    typedef struct {
        logic [31:0] rd_s;
        logic [31:0] rd_u;
        logic        err;
        int          lat;
        int          n_re;
        int          n_we;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rd_s = 32'h0;
    logic [31:0] ref_rd_u = 32'h0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t_apply = 0;
    bit          busy = 1'b0;

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_inputs(input logic [1:0] rd, input logic [1:0] wr,
                              input logic [31:0] addr, input logic [31:0] wdata);
        bus_s.MemRead = rd;  bus_s.MemWrite = wr;  bus_s.Address = addr;  bus_s.WriteData = wdata;
        bus_u.MemRead = rd;  bus_u.MemWrite = wr;  bus_u.Address = addr;  bus_u.WriteData = wdata;
    endtask

    // Hold the request while Stall is high; release it right after the Done cycle.
    task automatic drive(input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        set_inputs(rd, wr, addr, wdata);
        t_apply = cyc;
        busy = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (!bus_s.Stall) break;
        end
        if (n == 20) begin
            $display("FAIL timeout: Stall never dropped, got 1 expected 0");
            $fatal(1, "timeout");
        end
        @(posedge Clk);
        #1;
        set_inputs(2'b00, 2'b00, 32'h0, 32'h0);
        busy = 1'b0;
    endtask

    // Reference model: arithmetic on a word array, one request at a time.
    task automatic issue(input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          sz, idx, off;
        logic [31:0] v, mask;
        bit          ill;
        sz  = (rd != 0) ? int'(rd) : int'(wr);
        idx = int'(addr[5:2]);
        off = int'(addr[1:0]);
        ill = (rd != 0 && wr != 0) || (sz == 2 && off % 2 == 1) || (sz == 1 && off != 0);
        e.err = ill;  e.n_re = 0;  e.n_we = 0;  e.lat = 1;
        if (!ill && rd != 0) begin
            e.lat = 3;  e.n_re = 1;
            v = ref_mem[idx] >> (8 * off);
            if (sz == 1) begin
                ref_rd_s = ref_mem[idx];
                ref_rd_u = ref_mem[idx];
            end else if (sz == 2) begin
                v = v & 32'hFFFF;
                ref_rd_u = v;
                ref_rd_s = (v >= 32'h8000) ? v - 32'h10000 : v;
            end else begin
                v = v & 32'hFF;
                ref_rd_u = v;
                ref_rd_s = (v >= 32'h80) ? v - 32'h100 : v;
            end
        end else if (!ill) begin
            e.n_we = 1;
            if (sz == 1) begin
                e.lat = 2;
                ref_mem[idx] = wdata;
            end else begin
                e.lat = 4;  e.n_re = 1;
                mask = ((sz == 2) ? 32'hFFFF : 32'hFF) << (8 * off);
                ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << (8 * off)) & mask);
            end
        end
        e.rd_s = ref_rd_s;
        e.rd_u = ref_rd_u;
        sb_q.push_back(e);
        drive(rd, wr, addr, wdata);
    endtask

    initial begin
        exp_t e;
        int   nre = 0;
        int   nwe = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                nre = 0;
                nwe = 0;
            end else begin
                if (re_s) nre++;
                if (we_s) nwe++;
                if (busy) check("stall_vs_done", {31'b0, bus_s.Stall}, {31'b0, !bus_s.Done});
                check("done_match", {31'b0, bus_u.Done}, {31'b0, bus_s.Done});
                if (bus_s.Done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("readdata_signed", bus_s.ReadData, e.rd_s);
                        check("readdata_unsigned", bus_u.ReadData, e.rd_u);
                        check("alignerr", {31'b0, bus_s.AlignErr}, {31'b0, e.err});
                        check("latency", 32'(cyc - t_apply), 32'(e.lat));
                        check("mem_re_count", 32'(nre), 32'(e.n_re));
                        check("mem_we_count", 32'(nwe), 32'(e.n_we));
                    end
                    nre = 0;
                    nwe = 0;
                end else if (bus_s.AlignErr) begin
                    check("alignerr_without_done", 32'd1, 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          op, sz, n;
        set_inputs(2'b00, 2'b00, 32'h0, 32'h0);
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_readdata", bus_s.ReadData, 32'h0);
        check("rst_done", {31'b0, bus_s.Done}, 32'h0);
        check("rst_alignerr", {31'b0, bus_s.AlignErr}, 32'h0);
        check("rst_mem_addr", {28'b0, addr_s}, 32'h0);
        check("rst_mem_wdata", wdata_s, 32'h0);
        check("rst_mem_we", {31'b0, we_s}, 32'h0);
        check("rst_mem_re", {31'b0, re_s}, 32'h0);
        Reset = 1'b0;
        @(negedge Clk);
        check("idle_stall", {31'b0, bus_s.Stall}, 32'h0);
        @(posedge Clk);
        #1;

        // Preload every word through word stores; high address bits vary.
        for (int i = 0; i < DEPTH; i++) begin
            a = $urandom;
            a[5:0] = {i[3:0], 2'b00};
            issue(2'b00, 2'b01, a, $urandom);
        end

        issue(2'b00, 2'b01, 32'h40, 32'h11223344);
        issue(2'b01, 2'b00, 32'h40, 32'h0);
        check("lw_const", bus_s.ReadData, 32'h11223344);
        issue(2'b00, 2'b11, 32'h42, 32'hDEADBEAA);
        issue(2'b01, 2'b00, 32'h40, 32'h0);
        check("sb_rmw_const", bus_s.ReadData, 32'h11AA3344);
        issue(2'b00, 2'b01, 32'h40, 32'h000080FF);
        issue(2'b11, 2'b00, 32'h41, 32'h0);
        check("lb_signed_const", bus_s.ReadData, 32'hFFFFFF80);
        check("lb_unsigned_const", bus_u.ReadData, 32'h00000080);
        issue(2'b10, 2'b00, 32'h40, 32'h0);
        check("lh_signed_const", bus_s.ReadData, 32'hFFFF80FF);
        issue(2'b10, 2'b00, 32'h43, 32'h0);
        issue(2'b00, 2'b01, 32'h42, 32'h12345678);
        issue(2'b01, 2'b01, 32'h40, 32'h12345678);
        check("illegal_keeps_readdata", bus_s.ReadData, 32'hFFFF80FF);

        // Reset during RD_WAIT of a half store: no write may reach the SRAM.
        set_inputs(2'b00, 2'b10, 32'h44, 32'h00005555);
        for (n = 0; n < 10; n++) begin
            @(negedge Clk);
            check("abort_no_we_before", {31'b0, we_s}, 32'h0);
            if (re_s) break;
        end
        check("abort_saw_mem_re", {31'b0, re_s}, 32'h1);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("abort_we_low", {31'b0, we_s}, 32'h0);
        check("abort_re_low", {31'b0, re_s}, 32'h0);
        check("abort_done_low", {31'b0, bus_s.Done}, 32'h0);
        set_inputs(2'b00, 2'b00, 32'h0, 32'h0);
        @(negedge Clk);
        check("abort_we_still_low", {31'b0, we_s}, 32'h0);
        Reset = 1'b0;
        ref_rd_s = 32'h0;
        ref_rd_u = 32'h0;
        @(negedge Clk);
        check("abort_readdata_cleared", bus_s.ReadData, 32'h0);
        check("abort_we_after", {31'b0, we_s}, 32'h0);
        @(posedge Clk);
        #1;

        for (int t = 0; t < 200; t++) begin
            op = int'($urandom_range(0, 9));
            sz = int'($urandom_range(1, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 1) a[1:0] = 2'b00;
                if (sz == 2) a[0] = 1'b0;
            end
            if (op < 4)
                issue(2'(sz), 2'b00, a, 32'h0);
            else if (op < 8)
                issue(2'b00, 2'(sz), a, $urandom);
            else if (op == 8)
                issue(2'(sz), 2'($urandom_range(1, 3)), a, $urandom);
            else begin
                repeat ($urandom_range(1, 3)) @(posedge Clk);
                #1;
            end
        end

        repeat (3) @(posedge Clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("sram_s[%0d]", i), sram_s[i], ref_mem[i]);
            check($sformatf("sram_u[%0d]", i), sram_u[i], ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
